// File: rtl/imem_loader.sv
// Byte-serial instruction-memory loader: packs a little-endian byte stream into
// 32-bit word writes and holds the CPU stalled until the image is loaded.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN for the running byte checksum.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | after reset, waiting for start; CPU held
// RECV  | accepting bytes into lanes 0..3 of the current word
// WRITE | one-cycle word write to the instruction store
// DONE  | image complete, CPU released; start begins a new load
module imem_loader #(
    parameter int DEPTH_BYTES = 128,
    parameter int CNT_W       = 6
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] word_count,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             busy,
    output logic             done,
    output logic             cpu_hold,
    output logic             err_overflow,
    output logic [7:0]       checksum
);

    localparam int               CAP   = DEPTH_BYTES / 4;
    localparam logic [CNT_W-1:0] CAP_W = CNT_W'(CAP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] word_ptr;
    logic [1:0]       byte_idx;
    logic [23:0]      word_buf;

    logic             start_acc;
    logic             hs;
    logic             last_word;
    logic             over_cap;
    logic [CNT_W-1:0] count_eff;

    assign start_acc = start && ((state == S_IDLE) || (state == S_DONE));
    assign hs        = byte_valid && byte_ready;
    assign last_word = (word_ptr + CNT_W'(1)) == count;
    assign over_cap  = word_count > CAP_W;
    assign count_eff = over_cap ? CAP_W : word_count;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                done = (state == S_DONE);
                if (start) begin
                    state_nxt = (count_eff == '0) ? S_DONE : S_RECV;
                end
            end
            S_RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (hs && (byte_idx == 2'd3)) begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_we    = 1'b1;
                busy      = 1'b1;
                state_nxt = last_word ? S_DONE : S_RECV;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Address and data are captured with the final lane so they are stable
    // throughout WRITE and simply hold afterwards.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            count        <= '0;
            word_ptr     <= '0;
            byte_idx     <= 2'd0;
            word_buf     <= 24'd0;
            mem_addr     <= 32'd0;
            mem_wdata    <= 32'd0;
            cpu_hold     <= 1'b1;
            err_overflow <= 1'b0;
        end else begin
            if (start_acc) begin
                count        <= count_eff;
                word_ptr     <= '0;
                byte_idx     <= 2'd0;
                err_overflow <= over_cap;
                cpu_hold     <= (count_eff != '0);
            end
            if (hs) begin
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0: word_buf[7:0]   <= byte_in;
                    2'd1: word_buf[15:8]  <= byte_in;
                    2'd2: word_buf[23:16] <= byte_in;
                    default: begin
                        mem_wdata <= {byte_in, word_buf};
                        mem_addr  <= 32'({word_ptr, 2'b00});
                    end
                endcase
            end
            if (state == S_WRITE) begin
                if (last_word) begin
                    cpu_hold <= 1'b0;
                end else begin
                    word_ptr <= word_ptr + CNT_W'(1);
                end
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            csum <= 8'd0;
        end else if (start_acc) begin
            csum <= 8'd0;
        end else if (hs) begin
            csum <= csum + byte_in;
        end
    end

    assign checksum = csum;
`else
    assign checksum = 8'd0;
`endif

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-serial instruction-memory loader for the single-cycle CPU: the write side of the instruction store the fetch stage reads. It accepts a stream of program bytes over a valid/ready handshake and packs them little-endian into 32-bit words (first byte → bits [7:0]). Each word is written into the instruction memory through a word-write port at byte address 4·n. It holds the CPU in reset-stall until the program image is complete.

## Interface
- `DEPTH_BYTES`, 128: instruction store size in bytes; capacity `DEPTH_BYTES/4` words.
- `CNT_W`, 6: width of `word_count`.
- `CLK`  in  1  clock; all state updates on rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a load; sampled only in IDLE or DONE.
- `word_count`  in  CNT_W  number of words to load, latched when `start` is accepted.
- `byte_in`  in  8  program byte.
- `byte_valid`  in  1  `byte_in` valid.
- `byte_ready`  out  1  loader can accept a byte this cycle.
- `mem_we`  out  1  word write strobe, one cycle per word.
- `mem_addr`  out  32  byte address of word written, always a multiple of 4.
- `mem_wdata`  out  32  assembled word.
- `busy`  out  1  load in progress.
- `done`  out  1  last load completed; held until the next accepted `start`.
- `cpu_hold`  out  1  stall request to the CPU PC register.
- `err_overflow`  out  1  `word_count` exceeded capacity at last `start`.
- `checksum`  out  8  additive checksum of accepted bytes (see Configuration).

## Operation
- States: IDLE, RECV, WRITE, DONE.
- IDLE: `start`=1 → latch count, clear word pointer, byte index, checksum. If the count is 0, go to DONE. Otherwise go to RECV.
- Count > `DEPTH_BYTES/4`: clamp to capacity, set `err_overflow`. `err_overflow` is cleared by the next accepted `start` that is within range.
- RECV: `byte_ready`=1. Each handshake (`byte_valid && byte_ready`) stores `byte_in` into lane `byte_idx` (0..3) and increments `byte_idx` mod 4. Acceptance of lane 3 → WRITE.
- WRITE: `byte_ready`=0. `mem_we`=1, `mem_addr`=`word_ptr`<<2, `mem_wdata`=assembled word. Next: DONE if `word_ptr`==count−1, else `word_ptr`++ and RECV.
- DONE: `done`=1, `busy`=0, `cpu_hold`=0. `start`=1 → behaves as in IDLE.
- `start` during RECV/WRITE is ignored.
- `busy`=1 in RECV and WRITE only.
- `cpu_hold` = 1 from reset until the first entry into DONE. It is 1 again from an accepted `start` until DONE.
- `mem_addr` and `mem_wdata` hold their last values outside WRITE. They are 0 after reset.

## Timing
- Reset values: state IDLE, `byte_ready` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `busy` 0, `done` 0, `cpu_hold` 1, `err_overflow` 0, `checksum` 0.
- Reset assertion mid-load aborts immediately. The partial word is discarded. Memory words already written are not touched.
- `start` accepted at edge k → RECV (`byte_ready`=1) in cycle k+1.
- With `byte_valid` held high, one word takes 5 cycles: 4 accept cycles + 1 WRITE cycle.
- `done` and `cpu_hold` change on the edge that leaves the final WRITE.
- Stalls: `byte_valid`=0 in RECV leaves all state unchanged. There is no timeout.
- Lane order is fixed by the order of acceptance, not by address.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined: `checksum` is the modulo-256 sum of every accepted byte since the last accepted `start`. It updates on the accepting edge.
- Not defined: checksum logic is absent and `checksum` is tied to 0. The port remains in both builds.

## Test plan
- Reset, then `start` with `word_count`=1 and bytes 0x13,0x05,0x10,0x00 back-to-back → single `mem_we` at `mem_addr`=0 with `mem_wdata`=0x00100513. `done`=1 and `cpu_hold`=0 five cycles after RECV entry.
- `word_count`=3 with `byte_valid` toggling every other cycle → writes at addresses 0x0, 0x4, 0x8 in order. `byte_ready` is 0 during each WRITE. No extra `mem_we`.
- `word_count`=40 with `DEPTH_BYTES`=128 → `err_overflow`=1. Exactly 32 writes, last at 0x7C, then DONE.
- `word_count`=0 → DONE on the next edge, no `mem_we`, `cpu_hold` drops.
- `Reset_n` low after 2 bytes of word 1 → all outputs return to their reset values asynchronously. A following load of 1 word writes address 0.
- With `IMEM_LOADER_CHECKSUM_EN`, bytes 0xFF,0x02,0x00,0x01 → `checksum`=0x02. Without it, `checksum` stays 0.
